// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Covers the key event record, the prefix/error scan codes, the error kinds and the decoder states.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ERR_FRAMING = 2'd0,
        ERR_PARITY  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_KBD     = 2'd3
    } ps2_err_e;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } ps2_dec_state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events with a sticky overflow flag.
// When full, a push only succeeds if a pop happens in the same clock.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  ps2_event_t                 wr_data_i,
    input  logic                       rd_en_i,
    output ps2_event_t                 rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_event_t        mem [DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              empty, full, doPush, doPop;

    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == CW'(DEPTH));
        doPop  = rd_en_i && !empty;
        doPush = wr_en_i && (!full || doPop);
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en_i && full && !doPop) overflow_q <= 1'b1;
        end
    end

    assign valid_o    = !empty;
    assign rd_data_o  = empty ? '0 : mem[rdPtr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronises and oversamples the pins, deframes 11-bit packets,
// folds E0/F0 prefixes into single key events and queues them in a FWFT FIFO.
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int SAMPLE_DIV    = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [1:0]                    err_kind
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [DIV_W-1:0]       div_q;
    logic                   tick_q;
    logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
    logic                   ps2ClkS, ps2DataS;
    logic                   prevClk_q;
    logic [10:0]            shift_q;
    logic [3:0]             cnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic                   byteVld_q;
    logic [7:0]             byte_q;
    logic                   fallEdge, frameDone, frameBad, timeoutHit, frmErr;
    ps2_err_e               frmKind;
    ps2_dec_state_e         state_q, state_d;
    logic                   push_q, push_d, decErr;
    ps2_event_t             ev_q, ev_d, headEv;
    logic                   frameErr_q;
    ps2_err_e               errKind_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            clkSync_q  <= '1;
            dataSync_q <= '1;
        end else begin
            div_q      <= (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + 1'b1;
            tick_q     <= (div_q == DIV_W'(SAMPLE_DIV - 1));
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign ps2ClkS  = clkSync_q[SYNC_STAGES-1];
    assign ps2DataS = dataSync_q[SYNC_STAGES-1];

    // shift_q holds start in bit 0, data in 8:1, parity in 9 and stop in 10 once complete
    always_comb begin
        fallEdge   = tick_q && prevClk_q && !ps2ClkS;
        frameDone  = (cnt_q == 4'd11);
        frameBad   = shift_q[0] || !shift_q[10] || !(^shift_q[9:1]);
        timeoutHit = tick_q && !fallEdge && !frameDone && (cnt_q != 4'd0)
                     && (tmo_q == TMO_W'(TIMEOUT_TICKS - 1));
        frmErr     = (frameDone && frameBad) || timeoutHit;
        if (timeoutHit)                          frmKind = ERR_TIMEOUT;
        else if (shift_q[0] || !shift_q[10])     frmKind = ERR_FRAMING;
        else                                     frmKind = ERR_PARITY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prevClk_q <= 1'b1;
            shift_q   <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            byteVld_q <= 1'b0;
            byte_q    <= '0;
        end else begin
            if (tick_q) prevClk_q <= ps2ClkS;
            byteVld_q <= frameDone && !frameBad;
            byte_q    <= shift_q[8:1];
            if (frameDone || timeoutHit) begin
                cnt_q <= '0;
                tmo_q <= '0;
            end else if (fallEdge) begin
                shift_q <= {ps2DataS, shift_q[10:1]};
                cnt_q   <= cnt_q + 4'd1;
                tmo_q   <= '0;
            end else if (tick_q && cnt_q != 4'd0) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // Prefix decoder; the completed event is registered before it reaches the FIFO
    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        ev_d    = '0;
        decErr  = 1'b0;
        if (byteVld_q) begin
            case (state_q)
                DEC_IDLE: begin
                    if (byte_q == PS2_EXT)                              state_d = DEC_EXT;
                    else if (byte_q == PS2_BRK)                         state_d = DEC_BRK;
                    else if (byte_q == PS2_ERR0 || byte_q == PS2_ERR1)  decErr  = 1'b1;
                    else begin
                        push_d = 1'b1;
                        ev_d   = '{ext: 1'b0, brk: 1'b0, code: byte_q};
                    end
                end
                DEC_EXT: begin
                    if (byte_q == PS2_BRK)       state_d = DEC_EXT_BRK;
                    else if (byte_q != PS2_EXT) begin
                        push_d  = 1'b1;
                        ev_d    = '{ext: 1'b1, brk: 1'b0, code: byte_q};
                        state_d = DEC_IDLE;
                    end
                end
                DEC_BRK: begin
                    if (byte_q != PS2_BRK) begin
                        push_d  = 1'b1;
                        ev_d    = '{ext: 1'b0, brk: 1'b1, code: byte_q};
                        state_d = DEC_IDLE;
                    end
                end
                default: begin
                    if (byte_q != PS2_BRK && byte_q != PS2_EXT) begin
                        push_d  = 1'b1;
                        ev_d    = '{ext: 1'b1, brk: 1'b1, code: byte_q};
                        state_d = DEC_IDLE;
                    end
                end
            endcase
        end
        if (frmErr) state_d = DEC_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DEC_IDLE;
            push_q     <= 1'b0;
            ev_q       <= '0;
            frameErr_q <= 1'b0;
            errKind_q  <= ERR_FRAMING;
        end else begin
            state_q    <= state_d;
            push_q     <= push_d;
            ev_q       <= ev_d;
            frameErr_q <= frmErr || decErr;
            if (frmErr)      errKind_q <= frmKind;
            else if (decErr) errKind_q <= ERR_KBD;
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (push_q),
        .wr_data_i  (ev_q),
        .rd_en_i    (rd_en),
        .rd_data_o  (headEv),
        .valid_o    (ev_valid),
        .count_o    (fifo_count),
        .overflow_o (overflow)
    );

    assign ev_code   = headEv.code;
    assign ev_break  = headEv.brk;
    assign ev_ext    = headEv.ext;
    assign frame_err = frameErr_q;
    assign err_kind  = errKind_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: bit-level PS/2 frames driven tick-aligned,
// events popped from the FIFO and compared against hand-computed values.
module tb_ps2_rx_decoder;

    localparam int SD    = 4;
    localparam int TMO   = 20;
    localparam int DEPTH = 8;
    localparam int HALF  = 3 * SD;

    logic       clk = 1'b0;
    logic       rst, ps2Clk, ps2Data, rdEn;
    logic       evValid, evBreak, evExt, overflow, frameErr;
    logic [7:0] evCode;
    logic [3:0] fifoCount;
    logic [1:0] errKind;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int errCnt = 0;
    int lastKind = 0;

    ps2_rx_decoder #(
        .SAMPLE_DIV(SD), .TIMEOUT_TICKS(TMO), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2Clk), .ps2_data(ps2Data), .rd_en(rdEn),
        .ev_valid(evValid), .ev_code(evCode), .ev_break(evBreak), .ev_ext(evExt),
        .fifo_count(fifoCount), .overflow(overflow), .frame_err(frameErr), .err_kind(errKind)
    );

    always #5 clk = ~clk;

    // Bench's own count of clock edges since reset release, used to locate sampling ticks
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Record every error pulse so tests can compare counts and kinds
    always @(negedge clk) begin
        if (frameErr) begin
            errCnt   = errCnt + 1;
            lastKind = int'(errKind);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] d, input logic flip);
        return {1'b1, (~^d) ^ flip, d, 1'b0};
    endfunction

    // mode 1: check exact ev_valid latency on the stop bit; mode 2: pop in the push clock
    task automatic applyStimulus(input logic [10:0] f, input int nBits, input int mode);
        int k, m;
        for (int i = 0; i < nBits; i++) begin
            ps2Data = f[i];
            ps2Clk  = 1'b1;
            waitCycles(HALF);
            ps2Clk = 1'b0;
            k = cyc;
            if (i == nBits - 1 && mode != 0) begin
                m = k + 3;
                while (m % SD != 1) m++;
                waitUntil(m + 2);
                if (mode == 1) checkOutput("lat_early", evValid, 1'b0);
                else           rdEn = 1'b1;
                waitUntil(m + 3);
                if (mode == 1) checkOutput("lat_valid", evValid, 1'b1);
                rdEn = 1'b0;
            end
            waitUntil(k + HALF);
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic flip = 1'b0, input int mode = 0);
        applyStimulus(makeFrame(d, flip), 11, mode);
        ps2Clk = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic popEvent(input string tag, input logic ext, input logic brk, input logic [7:0] code);
        checkOutput({tag, "_valid"}, evValid, 1'b1);
        checkOutput({tag, "_code"}, evCode, code);
        checkOutput({tag, "_ext"}, evExt, ext);
        checkOutput({tag, "_brk"}, evBreak, brk);
        rdEn = 1'b1;
        waitCycles(1);
        rdEn = 1'b0;
    endtask

    logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4B};
    int errBase;

    initial begin
        rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; rdEn = 1'b0;
        waitCycles(3);
        checkOutput("rst_valid", evValid, 1'b0);
        checkOutput("rst_count", fifoCount, 4'd0);
        checkOutput("rst_ovf", overflow, 1'b0);
        checkOutput("rst_err", frameErr, 1'b0);
        rst = 1'b0;
        waitCycles(2 * HALF);

        // Single make code with latency check
        sendByte(8'h1C, 1'b0, 1);
        checkOutput("one_count", fifoCount, 4'd1);
        popEvent("one", 1'b0, 1'b0, 8'h1C);
        checkOutput("one_empty", evValid, 1'b0);

        // Extended break and plain break
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        checkOutput("extbrk_count", fifoCount, 4'd1);
        popEvent("extbrk", 1'b1, 1'b1, 8'h75);
        sendByte(8'hF0); sendByte(8'h1C);
        popEvent("brk", 1'b0, 1'b1, 8'h1C);
        checkOutput("clean_errs", errCnt, 0);

        // Parity error, then recovery
        sendByte(8'h1C, 1'b1);
        checkOutput("par_errcnt", errCnt, 1);
        checkOutput("par_kind", lastKind, 1);
        checkOutput("par_noev", evValid, 1'b0);
        sendByte(8'hE0); sendByte(8'h74);
        popEvent("ext", 1'b1, 1'b0, 8'h74);

        // Partial frame times out
        applyStimulus(makeFrame(8'h29, 1'b0), 5, 0);
        ps2Clk = 1'b1;
        waitCycles((TMO + 10) * SD);
        checkOutput("tmo_errcnt", errCnt, 2);
        checkOutput("tmo_kind", lastKind, 2);
        sendByte(8'h29);
        popEvent("aftmo", 1'b0, 1'b0, 8'h29);

        // Keyboard error code
        sendByte(8'hFF);
        checkOutput("kbd_errcnt", errCnt, 3);
        checkOutput("kbd_kind", lastKind, 3);
        checkOutput("kbd_noev", evValid, 1'b0);
        sendByte(8'h16);
        popEvent("afkbd", 1'b0, 1'b0, 8'h16);

        // Fill, simultaneous push/pop while full, then overflow
        for (int i = 0; i < DEPTH; i++) sendByte(codes[i]);
        checkOutput("full_count", fifoCount, 4'd8);
        checkOutput("full_noovf", overflow, 1'b0);
        sendByte(codes[8], 1'b0, 2);
        checkOutput("pp_count", fifoCount, 4'd8);
        checkOutput("pp_noovf", overflow, 1'b0);
        sendByte(codes[9]);
        checkOutput("ovf_count", fifoCount, 4'd8);
        checkOutput("ovf_set", overflow, 1'b1);
        for (int i = 1; i <= DEPTH; i++) popEvent($sformatf("drain%0d", i), 1'b0, 1'b0, codes[i]);
        checkOutput("drain_empty", fifoCount, 4'd0);
        checkOutput("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame with a queued event and sticky flags set
        sendByte(8'h66);
        errBase = errCnt;
        applyStimulus(makeFrame(8'h33, 1'b0), 6, 0);
        ps2Clk = 1'b1;
        rst = 1'b1;
        waitCycles(3);
        checkOutput("mrst_valid", evValid, 1'b0);
        checkOutput("mrst_count", fifoCount, 4'd0);
        checkOutput("mrst_ovf", overflow, 1'b0);
        checkOutput("mrst_kind", errKind, 2'd0);
        checkOutput("mrst_code", evCode, 8'h00);
        rst = 1'b0;
        waitCycles((TMO + 10) * SD);
        checkOutput("mrst_noerr", errCnt, errBase);
        sendByte(8'h5A);
        popEvent("afrst", 1'b0, 1'b0, 8'h5A);
        checkOutput("final_errs", errCnt, errBase);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
